// File: rtl/modsq_iter_ctrl.sv
// -----------------------------------------------------------------------------
// modsq_iter_ctrl
//
// Iteration controller between the host shell and an external modular squaring
// core. A start request splits sq_in into BIT_LEN-wide redundant coefficients,
// pushes them through IO_STAGES input registers to the core, launches the core,
// counts its per-iteration core_valid pulses up to the programmed iteration
// count and pipes results back out through IO_STAGES output registers.
//
// Optional feature macro: MODSQ_INTERMEDIATE_EN
//   defined   : every accepted core result is presented on sq_out with valid.
//   undefined : only the final result of a run is presented (valid == done).
//
// Handshake semantics (single rule for every pulse in this block):
//   start, core_valid, valid, done and core_start are single-cycle qualifiers;
//   there is no back-pressure. A pulse is consumed on the edge it is sampled
//   in an accepting state and ignored in any other state.
//
// Ports
//   clk, reset   : single clock, synchronous active-high reset
//   start, abort : run launch (IDLE only) / run cancel (non-IDLE only)
//   iterations   : squaring count, captured with start
//   sq_in        : MOD_LEN-bit initial value, captured with start
//   sq_out       : NUM_ELEMENTS slots of OUT_WORD_BITS, zero-extended results
//   valid, done  : result pulse / end-of-run pulse
//   busy         : controller not in IDLE
//   iter_count   : core results accepted in current/last run
//   core_reset   : held high except while the core runs
//   core_start   : one-cycle core launch pulse
//   core_sq_in   : coefficients to the core
//   core_sq_out  : core result, qualified by core_valid
//   core_valid   : one pulse per completed squaring
// -----------------------------------------------------------------------------
module modsq_iter_ctrl #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int BIT_LEN            = 17,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int IO_STAGES          = 3,
    parameter int ITER_W             = 64,
    parameter int OUT_WORD_BITS      = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [ITER_W-1:0]                     iterations,
    input  logic [MOD_LEN-1:0]                    sq_in,
    output logic [NUM_ELEMENTS*OUT_WORD_BITS-1:0] sq_out,
    output logic                                  valid,
    output logic                                  done,
    output logic                                  busy,
    output logic [ITER_W-1:0]                     iter_count,
    output logic                                  core_reset,
    output logic                                  core_start,
    output logic [NUM_ELEMENTS*BIT_LEN-1:0]       core_sq_in,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0]       core_sq_out,
    input  logic                                  core_valid
);

    localparam int NUM_WORDS = MOD_LEN / WORD_LEN;
    localparam int CORE_W    = NUM_ELEMENTS * BIT_LEN;
    localparam int OUT_W     = NUM_ELEMENTS * OUT_WORD_BITS;
    localparam int CNT_W     = $clog2(IO_STAGES + 1) + 1;
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(IO_STAGES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(IO_STAGES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [ITER_W-1:0] iter_target;

    logic              accept;      // core_valid counted this cycle
    logic              final_hit;   // accepted pulse completes the run
    logic              enter;       // accepted pulse enters the output pipe
    logic              abort_hit;   // abort honoured this cycle
    logic              zero_done;   // done for a zero-iteration run

    logic [CORE_W-1:0] split_in;
    logic [OUT_W-1:0]  out_wide;
    logic [CORE_W-1:0] in_pipe  [IO_STAGES];
    logic [CORE_W-1:0] out_data [IO_STAGES];
    logic [IO_STAGES-1:0] out_vld;
    logic [IO_STAGES-1:0] out_tag;

    assign core_sq_in = in_pipe[IO_STAGES-1];
    assign abort_hit  = abort && (state != IDLE);

    // Split the non-redundant input into zero-extended coefficients; the
    // redundant top coefficients stay zero.
    always_comb begin
        split_in = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            split_in[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(sq_in[j*WORD_LEN +: WORD_LEN]);
        end
    end

    always_comb begin
        out_wide = '0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            out_wide[j*OUT_WORD_BITS +: OUT_WORD_BITS] =
                OUT_WORD_BITS'(out_data[IO_STAGES-1][j*BIT_LEN +: BIT_LEN]);
        end
    end

    // Next-state logic. LOAD spans IO_STAGES cycles so that core_start is seen
    // one full cycle after the last input stage has settled. FLUSH spans
    // IO_STAGES+1 cycles so its last cycle is the one presenting the final
    // valid/done; busy drops on the following edge.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        final_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_next   = '0;
                    next_state = (iterations == '0) ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                if (cnt == LOAD_LAST) begin
                    cnt_next   = '0;
                    next_state = LAUNCH;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            LAUNCH: next_state = RUN;
            RUN: begin
                if (core_valid) begin
                    accept = 1'b1;
                    if ((iter_count + ITER_W'(1)) == iter_target) begin
                        final_hit  = 1'b1;
                        cnt_next   = '0;
                        next_state = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
        if (abort_hit) begin
            next_state = IDLE;
            accept     = 1'b0;
            final_hit  = 1'b0;
        end
    end

`ifdef MODSQ_INTERMEDIATE_EN
    assign enter = accept;
`else
    assign enter = final_hit;
`endif

    // Zero-iteration runs have no final result, so done is raised to appear
    // in the last FLUSH cycle, where a final valid would otherwise sit.
    assign zero_done = (state == FLUSH) && (cnt == LOAD_LAST) &&
                       (iter_target == '0) && !abort_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            iter_target <= '0;
            iter_count  <= '0;
            busy        <= 1'b0;
            core_start  <= 1'b0;
            core_reset  <= 1'b1;
            valid       <= 1'b0;
            done        <= 1'b0;
            sq_out      <= '0;
            out_vld     <= '0;
            out_tag     <= '0;
            for (int k = 0; k < IO_STAGES; k++) begin
                in_pipe[k]  <= '0;
                out_data[k] <= '0;
            end
        end else begin
            state      <= next_state;
            cnt        <= cnt_next;
            busy       <= (next_state != IDLE);
            core_start <= (next_state == LAUNCH);
            core_reset <= !((next_state == LAUNCH) || (next_state == RUN));

            if ((state == IDLE) && start) begin
                iter_target <= iterations;
                iter_count  <= '0;
                in_pipe[0]  <= split_in;
            end
            for (int k = 1; k < IO_STAGES; k++) begin
                in_pipe[k] <= in_pipe[k-1];
            end

            if (accept) begin
                iter_count <= iter_count + ITER_W'(1);
            end

            // Output pipe: data registers only move alongside a valid bit, so
            // sq_out keeps its last result between pulses.
            out_vld[0] <= enter;
            out_tag[0] <= final_hit;
            if (enter) begin
                out_data[0] <= core_sq_out;
            end
            for (int k = 1; k < IO_STAGES; k++) begin
                out_vld[k] <= out_vld[k-1];
                out_tag[k] <= out_tag[k-1];
                if (out_vld[k-1]) begin
                    out_data[k] <= out_data[k-1];
                end
            end
            valid <= out_vld[IO_STAGES-1];
            done  <= (out_vld[IO_STAGES-1] && out_tag[IO_STAGES-1]) || zero_done;
            if (out_vld[IO_STAGES-1] && !abort_hit) begin
                sq_out <= out_wide;
            end

            if (abort_hit) begin
                out_vld <= '0;
                out_tag <= '0;
                valid   <= 1'b0;
                done    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modsq_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modsq_iter_ctrl
//
// Bench for modsq_iter_ctrl with default parameters. A behavioural core model
// pulses core_valid every `gap` cycles while core_reset is low; expected
// outputs are derived from the run rules: the first `iterations` core results
// are accepted, the final one (or all of them with MODSQ_INTERMEDIATE_EN)
// appears on sq_out IO_STAGES edges after its core_valid edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_modsq_iter_ctrl;

    localparam int MOD_LEN  = 1024;
    localparam int WORD_LEN = 16;
    localparam int BIT_LEN  = 17;
    localparam int NE       = MOD_LEN / WORD_LEN + 2;
    localparam int S        = 3;
    localparam int ITER_W   = 64;
    localparam int OWB      = 32;
    localparam int CW       = NE * BIT_LEN;
    localparam int OW       = NE * OWB;
`ifdef MODSQ_INTERMEDIATE_EN
    localparam bit INTER = 1'b1;
`else
    localparam bit INTER = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              start;
    logic              abort;
    logic [ITER_W-1:0] iterations;
    logic [MOD_LEN-1:0] sq_in;
    logic [OW-1:0]     sq_out;
    logic              valid;
    logic              done;
    logic              busy;
    logic [ITER_W-1:0] iter_count;
    logic              core_reset;
    logic              core_start;
    logic [CW-1:0]     core_sq_in;
    logic [CW-1:0]     core_sq_out;
    logic              core_valid;

    modsq_iter_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .iterations  (iterations),
        .sq_in       (sq_in),
        .sq_out      (sq_out),
        .valid       (valid),
        .done        (done),
        .busy        (busy),
        .iter_count  (iter_count),
        .core_reset  (core_reset),
        .core_start  (core_start),
        .core_sq_in  (core_sq_in),
        .core_sq_out (core_sq_out),
        .core_valid  (core_valid)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ---------------- core model ----------------
    int            gap = 5;
    int            mcnt = 0;
    logic          core_valid_m = 1'b0;
    logic [CW-1:0] data_m = '0;
    logic          inj_valid = 1'b0;
    logic [CW-1:0] inj_data = '0;

    assign core_valid  = core_valid_m | inj_valid;
    assign core_sq_out = inj_valid ? inj_data : data_m;

    function automatic logic [CW-1:0] rand_core();
        logic [CW-1:0] r;
        logic [31:0]   t;
        r = '0;
        for (int j = 0; j < NE; j++) begin
            t = $urandom;
            r[j*BIT_LEN +: BIT_LEN] = t[BIT_LEN-1:0];
        end
        return r;
    endfunction

    function automatic logic [MOD_LEN-1:0] rand_sq();
        logic [MOD_LEN-1:0] r;
        for (int i = 0; i < MOD_LEN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [CW-1:0] split_ref(input logic [MOD_LEN-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int j = 0; j < MOD_LEN / WORD_LEN; j++)
            r[j*BIT_LEN +: BIT_LEN] = {{(BIT_LEN-WORD_LEN){1'b0}}, v[j*WORD_LEN +: WORD_LEN]};
        return r;
    endfunction

    function automatic logic [OW-1:0] widen_ref(input logic [CW-1:0] c);
        logic [OW-1:0] r;
        r = '0;
        for (int j = 0; j < NE; j++)
            r[j*OWB +: OWB] = {{(OWB-BIT_LEN){1'b0}}, c[j*BIT_LEN +: BIT_LEN]};
        return r;
    endfunction

    always @(negedge clk) begin
        if (core_reset !== 1'b0) begin
            mcnt         = 0;
            core_valid_m = 1'b0;
        end else begin
            mcnt = mcnt + 1;
            if (mcnt % gap == 0) begin
                core_valid_m = 1'b1;
                data_m       = rand_core();
            end else begin
                core_valid_m = 1'b0;
            end
        end
    end

    // ---------------- logs ----------------
    logic [CW-1:0] pulse_q[$];
    int            pulse_cyc_q[$];
    logic [OW-1:0] vq_data[$];
    int            vq_cyc[$];
    bit            vq_done[$];
    int            start_cyc_q[$];
    int            done_cnt = 0;
    int            done_cyc = -1;
    logic [OW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (core_valid_m && !reset) begin
            pulse_q.push_back(data_m);
            pulse_cyc_q.push_back(cyc);
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (!reset) begin
            if (valid === 1'b1) begin
                vq_data.push_back(sq_out);
                vq_cyc.push_back(cyc);
                vq_done.push_back(done === 1'b1);
            end
            if (done === 1'b1) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (core_start === 1'b1) start_cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        pulse_q.delete(); pulse_cyc_q.delete();
        vq_data.delete(); vq_cyc.delete(); vq_done.delete();
        start_cyc_q.delete(); exp_q.delete(); exp_cyc_q.delete();
        done_cnt = 0; done_cyc = -1;
    endtask

    // Returns the edge index E0 at which start was sampled.
    task automatic do_start(input logic [ITER_W-1:0] n, input logic [MOD_LEN-1:0] v,
                            output int e0);
        @(negedge clk);
        iterations = n; sq_in = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_pulses(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pulse_cyc_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Scoreboard: expected sq_out values and cycles for an n-iteration run.
    task automatic build_exp(input int n);
        exp_q.delete(); exp_cyc_q.delete();
        for (int i = 0; i < n && i < pulse_q.size(); i++) begin
            if (INTER || i == n - 1) begin
                exp_q.push_back(widen_ref(pulse_q[i]));
                exp_cyc_q.push_back(pulse_cyc_q[i] + S);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
        checks++; if (iter_count !== '0) begin failures++; $display("FAIL reset_iter_count got=%0d exp=0", iter_count); end
        checks++; if (sq_out !== '0) begin failures++; $display("FAIL reset_sq_out got_lo=%h exp=0", sq_out[63:0]); end
        checks++; if (core_sq_in !== '0) begin failures++; $display("FAIL reset_core_sq_in got_lo=%h exp=0", core_sq_in[63:0]); end
    endtask

    task automatic test_basic();
        logic [MOD_LEN-1:0] v;
        int e0;
        bit ok;
        clear_logs();
        gap = 5;
        v = rand_sq();
        v[15:0] = 16'h1234;
        do_start(ITER_W'(4), v, e0);
        wait_pulses(4, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_pulse_timeout got=%0d exp=4", pulse_q.size()); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL basic_core_reset_after_final got=%b exp=1", core_reset); end
        wait_done(ok);
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_idle_timeout got=busy exp=idle"); end
        repeat (6) @(negedge clk);
        checks++; if (start_cyc_q.size() !== 1 || start_cyc_q[0] !== e0 + S) begin
            failures++; $display("FAIL basic_core_start_cycle got_n=%0d exp_cycle=%0d", start_cyc_q.size(), e0 + S); end
        checks++; if (core_sq_in !== split_ref(v)) begin
            failures++; $display("FAIL basic_core_sq_in got_lo=%h exp_lo=%h", core_sq_in[63:0], split_ref(v)); end
        checks++; if (core_sq_in[BIT_LEN-1:0] !== 17'h01234) begin
            failures++; $display("FAIL basic_coef0 got=%h exp=01234", core_sq_in[BIT_LEN-1:0]); end
        checks++; if (core_sq_in[CW-1 -: 2*BIT_LEN] !== '0) begin
            failures++; $display("FAIL basic_redundant got=%h exp=0", core_sq_in[CW-1 -: 2*BIT_LEN]); end
        checks++; if (iter_count !== ITER_W'(4)) begin failures++; $display("FAIL basic_iter_count got=%0d exp=4", iter_count); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
        checks++; if (pulse_cyc_q.size() < 4 || done_cyc !== pulse_cyc_q[3] + S) begin
            failures++; $display("FAIL basic_done_cycle got=%0d exp=4th_valid+%0d", done_cyc, S); end
        build_exp(4);
        checks++; if (vq_data.size() !== exp_q.size()) begin
            failures++; $display("FAIL basic_valid_count got=%0d exp=%0d", vq_data.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < vq_data.size(); k++) begin
            checks++; if (vq_data[k] !== exp_q[k] || vq_cyc[k] !== exp_cyc_q[k]) begin
                failures++; $display("FAIL basic_result[%0d] got_lo=%h@%0d exp_lo=%h@%0d", k,
                                     vq_data[k][63:0], vq_cyc[k], exp_q[k][63:0], exp_cyc_q[k]); end
        end
    endtask

    task automatic test_zero_iterations();
        int e0;
        bit ok;
        clear_logs();
        do_start('0, rand_sq(), e0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL zero_done_timeout got=none exp=pulse"); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy_at_done got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after_done got=%b exp=0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (start_cyc_q.size() !== 0) begin failures++; $display("FAIL zero_core_start got=%0d exp=0", start_cyc_q.size()); end
        checks++; if (vq_data.size() !== 0) begin failures++; $display("FAIL zero_valid got=%0d exp=0", vq_data.size()); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
        checks++; if (iter_count !== '0) begin failures++; $display("FAIL zero_iter_count got=%0d exp=0", iter_count); end
    endtask

    task automatic test_abort();
        int e0;
        bit ok;
        clear_logs();
        gap = 5;
        do_start(ITER_W'(10), rand_sq(), e0);
        wait_pulses(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_pulse_timeout got=%0d exp=2", pulse_q.size()); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL abort_core_reset got=%b exp=1", core_reset); end
        repeat (30) @(negedge clk);
        checks++; if (iter_count !== ITER_W'(2)) begin failures++; $display("FAIL abort_iter_count got=%0d exp=2", iter_count); end
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        // Only the first result can have left the pipe before the abort.
        checks++; if (vq_data.size() !== (INTER ? 1 : 0)) begin
            failures++; $display("FAIL abort_valid_count got=%0d exp=%0d", vq_data.size(), INTER ? 1 : 0); end
    endtask

    task automatic test_start_while_busy();
        logic [MOD_LEN-1:0] v1;
        int e0;
        int n;
        bit ok;
        clear_logs();
        gap = $urandom_range(2, 6);
        n = $urandom_range(3, 5);
        v1 = rand_sq();
        do_start(ITER_W'(n), v1, e0);
        wait_pulses(1, ok);
        iterations = ITER_W'(99); sq_in = rand_sq(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL busy_start_done_timeout got=none exp=done"); end
        wait_idle(ok);
        repeat (5) @(negedge clk);
        checks++; if (iter_count !== ITER_W'(n)) begin failures++; $display("FAIL busy_start_iter_count got=%0d exp=%0d", iter_count, n); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", done_cnt); end
        checks++; if (start_cyc_q.size() !== 1) begin failures++; $display("FAIL busy_start_core_start got=%0d exp=1", start_cyc_q.size()); end
        checks++; if (core_sq_in !== split_ref(v1)) begin failures++; $display("FAIL busy_start_core_sq_in got_lo=%h exp_lo=%h", core_sq_in[63:0], split_ref(v1)); end
        checks++; if (pulse_q.size() < n || sq_out !== widen_ref(pulse_q[n-1])) begin
            failures++; $display("FAIL busy_start_final got_lo=%h", sq_out[63:0]); end
    endtask

    task automatic test_stray_pulses();
        logic [ITER_W-1:0] ic0;
        int e0;
        bit ok;
        // Strays while idle.
        clear_logs();
        ic0 = iter_count;
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            inj_data = rand_core(); inj_valid = 1'b1;
            @(negedge clk);
            inj_valid = 1'b0;
        end
        repeat (6) @(negedge clk);
        checks++; if (iter_count !== ic0) begin failures++; $display("FAIL stray_idle_count got=%0d exp=%0d", iter_count, ic0); end
        checks++; if (vq_data.size() !== 0 || busy !== 1'b0) begin failures++; $display("FAIL stray_idle_valid got=%0d exp=0", vq_data.size()); end
        // Stray during FLUSH.
        clear_logs();
        gap = 4;
        do_start(ITER_W'(2), rand_sq(), e0);
        wait_pulses(2, ok);
        inj_data = rand_core(); inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        wait_done(ok);
        wait_idle(ok);
        repeat (5) @(negedge clk);
        checks++; if (iter_count !== ITER_W'(2)) begin failures++; $display("FAIL stray_flush_count got=%0d exp=2", iter_count); end
        build_exp(2);
        checks++; if (vq_data.size() !== exp_q.size()) begin failures++; $display("FAIL stray_flush_valid_count got=%0d exp=%0d", vq_data.size(), exp_q.size()); end
        checks++; if (pulse_q.size() < 2 || sq_out !== widen_ref(pulse_q[1])) begin failures++; $display("FAIL stray_flush_result got_lo=%h", sq_out[63:0]); end
        // abort and core_valid colliding.
        clear_logs();
        gap = 5;
        do_start(ITER_W'(5), rand_sq(), e0);
        wait_pulses(1, ok);
        inj_data = rand_core(); inj_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL collide_busy got=%b exp=0", busy); end
        repeat (12) @(negedge clk);
        checks++; if (iter_count !== ITER_W'(1)) begin failures++; $display("FAIL collide_count got=%0d exp=1", iter_count); end
        checks++; if (vq_data.size() !== 0 || done_cnt !== 0) begin failures++; $display("FAIL collide_outputs got_valid=%0d got_done=%0d exp=0", vq_data.size(), done_cnt); end
    endtask

    task automatic test_back_to_back();
        int e0;
        bit ok;
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            gap = $urandom_range(2, 6);
            iterations = ITER_W'(3); sq_in = rand_sq(); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            e0 = cyc;
            wait_done(ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_done_timeout run=%0d got=none exp=done", r); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_at_done run=%0d got=%b exp=1", r, busy); end
            checks++; if (start_cyc_q.size() !== 1 || start_cyc_q[0] !== e0 + S) begin failures++; $display("FAIL b2b_core_start run=%0d exp_cycle=%0d", r, e0 + S); end
            build_exp(3);
            checks++; if (vq_data.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_valid_count run=%0d got=%0d exp=%0d", r, vq_data.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < vq_data.size(); k++) begin
                checks++; if (vq_data[k] !== exp_q[k] || vq_cyc[k] !== exp_cyc_q[k] ||
                              vq_done[k] !== (k == exp_q.size() - 1)) begin
                    failures++; $display("FAIL b2b_result run=%0d idx=%0d got_lo=%h@%0d done=%0b exp_lo=%h@%0d", r, k,
                                         vq_data[k][63:0], vq_cyc[k], vq_done[k], exp_q[k][63:0], exp_cyc_q[k]); end
            end
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_after_done run=%0d got=%b exp=0", r, busy); end
        end
        wait_idle(ok);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int e0;
        bit ok;
        clear_logs();
        gap = 5;
        do_start(ITER_W'(6), rand_sq(), e0);
        wait_pulses(1, ok);
        reset = 1'b1; abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0 || core_reset !== 1'b1 || core_start !== 1'b0) begin
            failures++; $display("FAIL midreset_ctrl got_busy=%b got_core_reset=%b exp=0/1", busy, core_reset); end
        checks++; if (iter_count !== '0 || valid !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL midreset_status got_count=%0d exp=0", iter_count); end
        checks++; if (sq_out !== '0 || core_sq_in !== '0) begin
            failures++; $display("FAIL midreset_data got_lo=%h exp=0", core_sq_in[63:0]); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        iterations = '0; sq_in = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic();
        test_zero_iterations();
        test_abort();
        test_start_while_busy();
        test_stray_pulses();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
